exec_unit_p: RTL

EXEC_UNIT_P -- requirements
Module: exec_unit_p

---
 rtl/exec_unit_p.sv | 125 ++++++++++++
 1 files changed

// File: rtl/exec_unit_p.sv
// Register-file datapath with IR-decoded ALU, condition flags and a program counter
// that supports PC-relative branches, absolute loads from the ALU and increment.
module exec_unit_p #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int OFFW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] d_in,
    input  logic          ir_ld,
    input  logic          w_en,
    input  logic          s_sel,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          pc_sel,
    input  logic          adr_sel,
    output logic [DW-1:0] d_out,
    output logic [DW-1:0] address,
    output logic          c,
    output logic          n,
    output logic          z
);

    localparam int AW = $clog2(NREG);

    localparam logic [3:0] OP_PASS_R = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_XOR    = 4'h5;
    localparam logic [3:0] OP_NOT    = 4'h6;
    localparam logic [3:0] OP_INC    = 4'h7;
    localparam logic [3:0] OP_DEC    = 4'h8;
    localparam logic [3:0] OP_SHL    = 4'h9;
    localparam logic [3:0] OP_SHR    = 4'hA;
    localparam logic [3:0] OP_PASS_S = 4'hB;

    localparam logic [DW:0]   ALU_ONE = 1;
    localparam logic [DW-1:0] PC_ONE  = 1;

    logic [DW-1:0] ir;
    logic [DW-1:0] pc;
    logic [DW-1:0] regs [NREG];

    logic [3:0]    op;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] s_idx;
    logic [DW-1:0] r_val;
    logic [DW-1:0] s_val;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] offset_ext;
    logic [DW-1:0] pc_target;
    logic [DW-1:0] pc_mux;
    logic          unused_ir_bits;

    assign op     = ir[DW-1:DW-4];
    assign w_idx  = ir[3*AW-1:2*AW];
    assign r_idx  = ir[2*AW-1:AW];
    assign s_idx  = ir[AW-1:0];
    assign r_val  = regs[r_idx];
    assign s_val  = s_sel ? d_in : regs[s_idx];
    assign unused_ir_bits = ^ir;

    // Every op produces a DW+1 result whose top bit is the carry/borrow/shifted-out bit.
    always_comb begin
        alu_wide = {1'b0, r_val};
        case (op)
            OP_PASS_R: alu_wide = {1'b0, r_val};
            OP_ADD:    alu_wide = {1'b0, r_val} + {1'b0, s_val};
            OP_SUB:    alu_wide = {1'b0, r_val} - {1'b0, s_val};
            OP_AND:    alu_wide = {1'b0, r_val & s_val};
            OP_OR:     alu_wide = {1'b0, r_val | s_val};
            OP_XOR:    alu_wide = {1'b0, r_val ^ s_val};
            OP_NOT:    alu_wide = {1'b0, ~r_val};
            OP_INC:    alu_wide = {1'b0, r_val} + ALU_ONE;
            OP_DEC:    alu_wide = {1'b0, r_val} - ALU_ONE;
            OP_SHL:    alu_wide = {r_val, 1'b0};
            OP_SHR:    alu_wide = {r_val[0], 1'b0, r_val[DW-1:1]};
            OP_PASS_S: alu_wide = {1'b0, s_val};
            default:   alu_wide = {1'b0, r_val};
        endcase
    end

    assign d_out      = alu_wide[DW-1:0];
    assign offset_ext = {{(DW-OFFW){ir[OFFW-1]}}, ir[OFFW-1:0]};
    assign pc_target  = pc + offset_ext;
    assign pc_mux     = pc_sel ? d_out : pc_target;
    assign address    = adr_sel ? r_val : pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (w_en) begin
            regs[w_idx] <= d_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c <= 1'b0;
            n <= 1'b0;
            z <= 1'b0;
        end else if (w_en) begin
            c <= alu_wide[DW];
            n <= d_out[DW-1];
            z <= (d_out == '0);
        end
    end

    // IR and PC both update from values decoded off the pre-edge IR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
            pc <= '0;
        end else begin
            if (ir_ld) ir <= d_in;
            if (pc_ld) pc <= pc_mux;
            else if (pc_inc) pc <= pc + PC_ONE;
        end
    end

endmodule
